// File: rtl/munoc_apb_splitter.sv
// -----------------------------------------------------------------------------
// munoc_apb_splitter
//
// Fans the single APB master port of the AXI-to-APB bridge node out to
// NUM_SLAVE APB peripheral ports. Each accepted access is decoded by base/mask
// and re-timed into a clean SETUP/ACCESS sequence on the downstream side. The
// block answers upstream itself in a one-cycle RESP state. Decode misses and
// slaves that never raise PREADY are terminated with PSLVERR, so a dead
// peripheral cannot stall the NoC.
//
// Optional error log: define MUNOC_APB_SPLITTER_ERROR_LOG_EN to build the
// sticky first-error log (err_valid/err_addr/err_cause, cleared by err_clear).
// Without the macro those outputs are tied low and err_clear is ignored.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   spaddr..spwstrb upstream APB request (from the bridge)
//   sprdata, spready, spslverr
//                   upstream APB response (registered, valid in RESP only)
//   mpsel           one-hot downstream select
//   mpaddr, mpwrite, mpenable, mpwdata, mpwstrb
//                   shared downstream request bus (zero when no slave selected)
//   mprdata, mpready, mpslverr
//                   packed downstream responses, slave i in slice i
//   err_valid, err_addr, err_cause, err_clear
//                   error log (cause 01 decode, 10 timeout, 11 slave error)
// -----------------------------------------------------------------------------
module munoc_apb_splitter #(
    parameter int                           NUM_SLAVE      = 4,
    parameter int                           BW_ADDR        = 32,
    parameter int                           BW_DATA        = 32,
    parameter logic [NUM_SLAVE*BW_ADDR-1:0] SLAVE_BASE     = {NUM_SLAVE{32'h0}},
    parameter logic [NUM_SLAVE*BW_ADDR-1:0] SLAVE_MASK     = {NUM_SLAVE{32'h0}},
    parameter int                           TIMEOUT_CYCLES = 255,
    parameter int                           BW_TIMEOUT     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    // upstream APB
    input  logic [BW_ADDR-1:0]             spaddr,
    input  logic                           spwrite,
    input  logic                           spsel,
    input  logic                           spenable,
    input  logic [BW_DATA-1:0]             spwdata,
    input  logic [BW_DATA/8-1:0]           spwstrb,
    output logic [BW_DATA-1:0]             sprdata,
    output logic                           spready,
    output logic                           spslverr,
    // downstream APB
    output logic [NUM_SLAVE-1:0]           mpsel,
    output logic [BW_ADDR-1:0]             mpaddr,
    output logic                           mpwrite,
    output logic                           mpenable,
    output logic [BW_DATA-1:0]             mpwdata,
    output logic [BW_DATA/8-1:0]           mpwstrb,
    input  logic [NUM_SLAVE*BW_DATA-1:0]   mprdata,
    input  logic [NUM_SLAVE-1:0]           mpready,
    input  logic [NUM_SLAVE-1:0]           mpslverr,
    // error log
    output logic                           err_valid,
    output logic [BW_ADDR-1:0]             err_addr,
    output logic [1:0]                     err_cause,
    input  logic                           err_clear
);

    localparam int IDX_W = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;

    // Counter is compared one bit wider so the increment never wraps before
    // it can be matched against the limit.
    localparam logic [BW_TIMEOUT:0] TIMEOUT_LIM = (BW_TIMEOUT + 1)'(TIMEOUT_CYCLES);
    localparam logic [BW_TIMEOUT:0] CNT_ONE     = {{BW_TIMEOUT{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BW_ADDR-1:0]     addr_q, addr_d;
    logic                   write_q, write_d;
    logic [BW_DATA-1:0]     wdata_q, wdata_d;
    logic [BW_DATA/8-1:0]   wstrb_q, wstrb_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BW_TIMEOUT-1:0]  cnt_q, cnt_d;
    logic [BW_DATA-1:0]     rdata_q, rdata_d;
    logic                   slverr_q, slverr_d;

    // -------------------------------------------------------------------------
    // Address decode and per-slave response unpacking
    // -------------------------------------------------------------------------
    logic [NUM_SLAVE-1:0]   dec_hit_vec;
    logic [BW_DATA-1:0]     slv_rdata [NUM_SLAVE];
    logic                   dec_hit;
    logic [IDX_W-1:0]       dec_idx;

    generate
        for (genvar gi = 0; gi < NUM_SLAVE; gi++) begin : g_slave
            localparam logic [BW_ADDR-1:0] BASE = SLAVE_BASE[gi*BW_ADDR +: BW_ADDR];
            localparam logic [BW_ADDR-1:0] MASK = SLAVE_MASK[gi*BW_ADDR +: BW_ADDR];
            assign dec_hit_vec[gi] = ((spaddr & MASK) == (BASE & MASK));
            assign slv_rdata[gi]   = mprdata[gi*BW_DATA +: BW_DATA];
        end
    endgenerate

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        dec_idx = '0;
        for (int i = NUM_SLAVE - 1; i >= 0; i--) begin
            if (dec_hit_vec[i]) begin
                dec_idx = IDX_W'(i);
            end
        end
    end

    assign dec_hit = |dec_hit_vec;

    // Response of the currently addressed slave
    logic                 sel_ready;
    logic                 sel_err;
    logic [BW_DATA-1:0]   sel_rdata;

    assign sel_ready = mpready[idx_q];
    assign sel_err   = mpslverr[idx_q];
    assign sel_rdata = slv_rdata[idx_q];

    // -------------------------------------------------------------------------
    // ACCESS-phase timeout
    // -------------------------------------------------------------------------
    logic [BW_TIMEOUT:0]  cnt_inc;
    logic                 timeout_hit;

    assign cnt_inc     = {1'b0, cnt_q} + CNT_ONE;
    // Fires on the ACCESS cycle that would bring the count to the limit, so
    // mpenable stays high for exactly TIMEOUT_CYCLES cycles.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIM);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;

        case (state_q)
            ST_IDLE: begin
                if (spsel && spenable) begin
                    addr_d  = spaddr;
                    write_d = spwrite;
                    wdata_d = spwdata;
                    wstrb_d = spwstrb;
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (dec_hit) begin
                        slverr_d = 1'b0;
                        state_d  = ST_SETUP;
                    end else begin
                        // Decode miss is answered locally, nothing goes out.
                        slverr_d = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end

            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                // Ready is checked first so it wins over a same-cycle timeout.
                if (sel_ready) begin
                    slverr_d = sel_err;
                    rdata_d  = (write_q || sel_err) ? '0 : sel_rdata;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_inc[BW_TIMEOUT-1:0];
                    if (timeout_hit) begin
                        slverr_d = 1'b1;
                        rdata_d  = '0;
                        state_d  = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                // Upstream request is deliberately not sampled here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (all derived from registered state, so reset clears them
    // immediately)
    // -------------------------------------------------------------------------
    always_comb begin
        mpsel    = '0;
        mpenable = 1'b0;
        mpaddr   = '0;
        mpwrite  = 1'b0;
        mpwdata  = '0;
        mpwstrb  = '0;
        spready  = 1'b0;
        sprdata  = '0;
        spslverr = 1'b0;

        case (state_q)
            ST_SETUP, ST_ACCESS: begin
                mpsel[idx_q] = 1'b1;
                mpenable     = (state_q == ST_ACCESS);
                mpaddr       = addr_q;
                mpwrite      = write_q;
                mpwdata      = wdata_q;
                mpwstrb      = wstrb_q;
            end
            ST_RESP: begin
                spready  = 1'b1;
                sprdata  = rdata_q;
                spslverr = slverr_q;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sticky first-error log
    // -------------------------------------------------------------------------
`ifdef MUNOC_APB_SPLITTER_ERROR_LOG_EN
    logic                 err_valid_q, err_valid_d;
    logic [BW_ADDR-1:0]   err_addr_q, err_addr_d;
    logic [1:0]           err_cause_q, err_cause_d;
    logic                 evt;
    logic [1:0]           evt_cause;
    logic [BW_ADDR-1:0]   evt_addr;

    always_comb begin
        evt       = 1'b0;
        evt_cause = 2'b00;
        evt_addr  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (spsel && spenable && !dec_hit) begin
                    evt       = 1'b1;
                    evt_cause = 2'b01;
                    evt_addr  = spaddr;
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    if (sel_err) begin
                        evt       = 1'b1;
                        evt_cause = 2'b11;
                    end
                end else if (timeout_hit) begin
                    evt       = 1'b1;
                    evt_cause = 2'b10;
                end
            end
            default: begin
            end
        endcase
    end

    // A clear and a new error in the same cycle leave the new error logged.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        if (err_clear) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_cause_d = 2'b00;
        end
        if (evt && (!err_valid_q || err_clear)) begin
            err_valid_d = 1'b1;
            err_addr_d  = evt_addr;
            err_cause_d = evt_cause;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= 2'b00;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear;

    assign err_valid = 1'b0;
    assign err_addr  = '0;
    assign err_cause = 2'b00;
`endif

endmodule

// File: tb/tb_munoc_apb_splitter.sv
module tb_munoc_apb_splitter;

`ifdef MUNOC_APB_SPLITTER_ERROR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   spaddr = '0;
    logic          spwrite = 1'b0;
    logic          spsel = 1'b0;
    logic          spenable = 1'b0;
    logic [31:0]   spwdata = '0;
    logic [3:0]    spwstrb = '0;
    logic [31:0]   sprdata;
    logic          spready;
    logic          spslverr;
    logic [NS-1:0] mpsel;
    logic [31:0]   mpaddr;
    logic          mpwrite;
    logic          mpenable;
    logic [31:0]   mpwdata;
    logic [3:0]    mpwstrb;
    logic [NS*32-1:0] mprdata = '0;
    logic [NS-1:0] mpready = '0;
    logic [NS-1:0] mpslverr = '0;
    logic          err_valid;
    logic [31:0]   err_addr;
    logic [1:0]    err_cause;
    logic          err_clear = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    munoc_apb_splitter #(
        .NUM_SLAVE      (NS),
        .BW_ADDR        (32),
        .BW_DATA        (32),
        .SLAVE_BASE     ({32'h0000_1000, 32'h0000_4000, 32'h0000_2000, 32'h0000_1000}),
        .SLAVE_MASK     ({32'h0000_FF00, 32'h0000_F000, 32'h0000_F000, 32'h0000_F000}),
        .TIMEOUT_CYCLES (4),
        .BW_TIMEOUT     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spaddr    (spaddr),
        .spwrite   (spwrite),
        .spsel     (spsel),
        .spenable  (spenable),
        .spwdata   (spwdata),
        .spwstrb   (spwstrb),
        .sprdata   (sprdata),
        .spready   (spready),
        .spslverr  (spslverr),
        .mpsel     (mpsel),
        .mpaddr    (mpaddr),
        .mpwrite   (mpwrite),
        .mpenable  (mpenable),
        .mpwdata   (mpwdata),
        .mpwstrb   (mpwstrb),
        .mprdata   (mprdata),
        .mpready   (mpready),
        .mpslverr  (mpslverr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_cause (err_cause),
        .err_clear (err_clear)
    );

    always #5 clk = ~clk;

    // Slave model: targeted slave returns slv_rdata, all others its inverse.
    // slv_wait < 0 means the slave never becomes ready.
    int          slv_wait  = 0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic [3:0]  slv_tgt   = '0;
    int          acc_cnt [NS] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (mpsel[i] && mpenable) begin
                mpready[i]  = (slv_wait >= 0) && (acc_cnt[i] >= slv_wait);
                mpslverr[i] = mpready[i] & slv_err;
                acc_cnt[i]  = acc_cnt[i] + 1;
            end else begin
                mpready[i]  = 1'b0;
                mpslverr[i] = 1'b0;
                acc_cnt[i]  = 0;
            end
            mprdata[i*32 +: 32] = slv_tgt[i] ? slv_rdata : ~slv_rdata;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          sw;
        logic        serr;
        logic [31:0] srdata;
        logic [3:0]  esel;
        int          eacc;
        logic [31:0] erdata;
        logic        eerr;
        int          elat;
    } vec_t;

    vec_t sb_q[$];

    function automatic vec_t mk(logic [31:0] a, logic w, logic [31:0] wd, logic [3:0] st,
                                int sw, logic se, logic [31:0] srd, logic [3:0] es,
                                int ea, logic [31:0] er, logic ee, int el);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = wd; v.strb = st;
        v.sw = sw; v.serr = se; v.srdata = srd; v.esel = es;
        v.eacc = ea; v.erdata = er; v.eerr = ee; v.elat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One upstream APB transfer; expected response is queued on issue and
    // checked when spready appears.
    task automatic xfer(input vec_t v, input bit clr);
        vec_t e;
        int   cyc, nset, nacc, nbus;
        bit   done;
        slv_wait = v.sw; slv_err = v.serr; slv_rdata = v.srdata; slv_tgt = v.esel;
        @(posedge clk); #1;
        spsel = 1'b1; spenable = 1'b0; spaddr = v.addr; spwrite = v.wr;
        spwdata = v.wdata; spwstrb = v.strb;
        @(posedge clk); #1;
        spenable = 1'b1;
        if (clr) err_clear = 1'b1;
        sb_q.push_back(v);
        cyc = 0; nset = 0; nacc = 0; nbus = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc >= 1) err_clear = 1'b0;
            if (mpsel != '0) begin
                if (mpsel !== v.esel || mpaddr !== v.addr || mpwrite !== v.wr ||
                    mpwdata !== v.wdata || mpwstrb !== v.strb) nbus++;
                if (mpenable) nacc++;
                else nset++;
            end else if (mpenable !== 1'b0) begin
                nbus++;
            end
            if (spready === 1'b1) begin
                done = 1'b1;
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    $display("[TB] xfer addr=0x%08h wr=%0d rdata=0x%08h slverr=%0d lat=%0d setup=%0d access=%0d",
                             e.addr, e.wr, sprdata, spslverr, cyc, nset, nacc);
                    chk("rdata",   sprdata,  e.erdata);
                    chk("slverr",  spslverr, e.eerr);
                    chk("latency", cyc,      e.elat);
                    chk("setup",   nset,     (e.esel != '0) ? 1 : 0);
                    chk("access",  nacc,     e.eacc);
                    chk("bus",     nbus,     0);
                end
            end else begin
                cyc++;
            end
        end
        if (!done) begin
            chk("spready_seen", 64'd0, 64'd1);
            sb_q.delete();
        end
        err_clear = 1'b0;
        @(posedge clk); #1;
        spsel = 1'b0; spenable = 1'b0; spaddr = '0; spwrite = 1'b0;
        spwdata = '0; spwstrb = '0;
        @(negedge clk);
        chk("spready_pulse", spready, 1'b0);
    endtask

    task automatic chk_log(input string tag, input logic v, input logic [1:0] c, input logic [31:0] a);
        chk({tag, "_valid"}, err_valid, LOG_EN ? v : 1'b0);
        chk({tag, "_cause"}, err_cause, LOG_EN ? c : 2'b00);
        chk({tag, "_addr"},  err_addr,  LOG_EN ? a : 32'h0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        //          addr      wr  wdata         strb  sw  se  srdata        esel    acc rdata         err lat
        tbl[0] = mk(32'h1004, 1, 32'hA5A5A5A5, 4'hF,  0, 0, 32'hDEADBEEF, 4'b0001, 1, 32'h0,        0, 3);
        tbl[1] = mk(32'h2008, 0, 32'h0,        4'h0,  3, 0, 32'h12345678, 4'b0010, 4, 32'h12345678, 0, 6);
        tbl[2] = mk(32'h9000, 0, 32'h0,        4'h0,  0, 0, 32'h0,        4'b0000, 0, 32'h0,        1, 1);
        tbl[3] = mk(32'h4010, 0, 32'h0,        4'h0, -1, 0, 32'h77777777, 4'b0100, 4, 32'h0,        1, 6);
        tbl[4] = mk(32'h1000, 0, 32'h0,        4'h0,  0, 0, 32'hCAFEF00D, 4'b0001, 1, 32'hCAFEF00D, 0, 3);
        tbl[5] = mk(32'h2FFC, 0, 32'h0,        4'h0,  1, 1, 32'h0BADF00D, 4'b0010, 2, 32'h0,        1, 4);
        tbl[6] = mk(32'h4000, 1, 32'h11223344, 4'h3,  2, 0, 32'h99999999, 4'b0100, 3, 32'h0,        0, 5);
        tbl[7] = mk(32'h4ABC, 0, 32'h0,        4'h0,  4, 0, 32'h44444444, 4'b0100, 4, 32'h0,        1, 6);
        tbl[8] = mk(32'h3000, 1, 32'h5555AAAA, 4'hF,  0, 0, 32'h0,        4'b0000, 0, 32'h0,        1, 1);
        tbl[9] = mk(32'h10F0, 0, 32'h0,        4'h0,  0, 0, 32'h55AA55AA, 4'b0001, 1, 32'h55AA55AA, 0, 3);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_up",   {sprdata, spready, spslverr}, 64'd0);
        chk("rst_sel",  {mpsel, mpenable, mpwrite}, 64'd0);
        chk("rst_bus",  {mpaddr, mpwdata}, 64'd0);
        chk("rst_strb", mpwstrb, 64'd0);
        chk("rst_log",  {err_valid, err_cause, err_addr}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven transfers
        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i], 1'b0);
        end

        // Reset asserted during ACCESS drops everything at once
        slv_wait = -1; slv_err = 1'b0; slv_tgt = 4'b0100; slv_rdata = 32'h0;
        @(posedge clk); #1;
        spsel = 1'b1; spenable = 1'b0; spaddr = 32'h4000; spwrite = 1'b0;
        @(posedge clk); #1;
        spenable = 1'b1;
        n = 0;
        while (mpenable !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_access", mpenable, 1'b1);
        #1;
        rst = 1'b1; spsel = 1'b0; spenable = 1'b0; spaddr = '0;
        #1;
        chk("midrst_sel", {mpsel, mpenable}, 64'd0);
        chk("midrst_addr", mpaddr, 64'd0);
        chk("midrst_up", {spready, spslverr, sprdata}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (spready !== 1'b0 || mpsel !== '0) bad++;
        end
        chk("midrst_no_resp", bad, 0);
        xfer(tbl[0], 1'b0);

        // Error log sequence
        chk_log("log_empty", 1'b0, 2'b00, 32'h0);
        xfer(mk(32'h9000, 0, 32'h0, 4'h0, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 1, 1), 1'b0);
        chk_log("log_miss", 1'b1, 2'b01, 32'h9000);
        xfer(mk(32'h4000, 0, 32'h0, 4'h0, -1, 0, 32'h0, 4'b0100, 4, 32'h0, 1, 6), 1'b0);
        chk_log("log_sticky", 1'b1, 2'b01, 32'h9000);
        pulse_clear();
        chk_log("log_clear", 1'b0, 2'b00, 32'h0);
        xfer(mk(32'h4040, 0, 32'h0, 4'h0, -1, 0, 32'h0, 4'b0100, 4, 32'h0, 1, 6), 1'b0);
        chk_log("log_timeout", 1'b1, 2'b10, 32'h4040);
        xfer(mk(32'h3004, 0, 32'h0, 4'h0, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 1, 1), 1'b1);
        chk_log("log_clr_same", 1'b1, 2'b01, 32'h3004);
        pulse_clear();
        xfer(mk(32'h2010, 0, 32'h0, 4'h0, 0, 1, 32'h13579BDF, 4'b0010, 1, 32'h0, 1, 3), 1'b0);
        chk_log("log_slverr", 1'b1, 2'b11, 32'h2010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
